ascii_frame_stats: RTL and testbench

- Streaming successor to the combinational ASCII classifier.
- Accepts characters over a valid/ready stream, classifies each one with a registered per-character output, and accumulates per-frame class counts.
- Emits a statistics record at each frame end (EOL character or in_last) over a second valid/ready handshake.
- Sits between a UART/byte-stream receiver and a text-processing or debug-statistics consumer.

---
 rtl/ascii_pkg.sv | 34 +++
 rtl/char_classify.sv | 25 ++
 rtl/ascii_frame_stats.sv | 148 ++++++++++++++
 tb/tb_ascii_frame_stats.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ascii_pkg.sv
// Shared ASCII range constants, classification record and frame-statistics FSM states.
package ascii_pkg;

    localparam logic [7:0] PRT_LO = 8'h21;
    localparam logic [7:0] PRT_HI = 8'h7E;
    localparam logic [7:0] NUM_LO = 8'h30;
    localparam logic [7:0] NUM_HI = 8'h39;
    localparam logic [7:0] CAP_LO = 8'h41;
    localparam logic [7:0] CAP_HI = 8'h5A;
    localparam logic [7:0] LC_LO  = 8'h61;
    localparam logic [7:0] LC_HI  = 8'h7A;
    localparam logic [7:0] SPACE  = 8'h20;
    localparam logic [7:0] EXT_LO = 8'h80;

    // Field order matches the cls output bus, MSB first.
    typedef struct packed {
        logic is_ext;
        logic is_space;
        logic is_printable;
        logic is_num;
        logic is_lc;
        logic is_cap;
    } char_class_t;

    typedef enum logic {
        COUNT  = 1'b0,
        REPORT = 1'b1
    } stat_state_e;

    function automatic logic in_range(input logic [7:0] c, input logic [7:0] lo, input logic [7:0] hi);
        return (c >= lo) && (c <= hi);
    endfunction

endpackage

// File: rtl/char_classify.sv
// Combinational ASCII classifier for 7- or 8-bit codes; 8-bit codes 0x80-0xFF are extended.
module char_classify
    import ascii_pkg::*;
#(
    parameter int CHAR_W = 7
) (
    input  logic [CHAR_W-1:0] code_i,
    output char_class_t       class_o
);

    logic [7:0] code8;
    assign code8 = 8'(code_i);

    always_comb begin
        class_o              = '0;
        class_o.is_printable = in_range(code8, PRT_LO, PRT_HI);
        class_o.is_num       = in_range(code8, NUM_LO, NUM_HI);
        class_o.is_cap       = in_range(code8, CAP_LO, CAP_HI);
        class_o.is_lc        = in_range(code8, LC_LO, LC_HI);
        class_o.is_space     = (code8 == SPACE);
        // A 7-bit code can never reach the extended range.
        class_o.is_ext       = (CHAR_W == 8) && (code8 >= EXT_LO);
    end

endmodule

// File: rtl/ascii_frame_stats.sv
// Streaming ASCII classifier with per-frame saturating class counters and a
// statistics record handed out over a valid/ready handshake at each frame end.
module ascii_frame_stats
    import ascii_pkg::*;
#(
    parameter int         CHAR_W   = 7,
    parameter int         CNT_W    = 8,
    parameter logic [7:0] EOL_CHAR = 8'h0A
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CHAR_W-1:0] in_char,
    input  logic              in_last,
    output logic              cls_valid,
    output logic [5:0]        cls,
    output logic              stat_valid,
    input  logic              stat_ready,
    output logic [CNT_W-1:0]  stat_chars,
    output logic [CNT_W-1:0]  stat_cap,
    output logic [CNT_W-1:0]  stat_lc,
    output logic [CNT_W-1:0]  stat_num,
    output logic [CNT_W-1:0]  stat_prt,
    output logic              stat_sat
);

    // Counter slots: 0 chars, 1 cap, 2 lc, 3 num, 4 prt.
    localparam int N_CNT = 5;

    char_class_t char_class;
    stat_state_e state_q;
    logic        in_ready_q;
    logic        stat_valid_q;
    logic        cls_valid_q;
    logic [5:0]  cls_q;
    logic        sat_q;
    logic        sat_d;
    logic [N_CNT-1:0][CNT_W-1:0] cnt_q;
    logic [N_CNT-1:0][CNT_W-1:0] cnt_d;
    logic [N_CNT-1:0] inc;
    logic [N_CNT-1:0] at_max;
    logic        accept;
    logic        frame_end;
    logic        clear;

    char_classify #(
        .CHAR_W (CHAR_W)
    ) u_classify (
        .code_i  (in_char),
        .class_o (char_class)
    );

    assign accept    = in_valid && in_ready_q;
    assign frame_end = accept && ((in_char == EOL_CHAR[CHAR_W-1:0]) || in_last);
    assign clear     = (state_q == REPORT) && stat_ready;
    assign inc       = {char_class.is_printable, char_class.is_num, char_class.is_lc,
                        char_class.is_cap, 1'b1} & {N_CNT{accept}};

    for (genvar gi = 0; gi < N_CNT; gi++) begin : g_max
        assign at_max[gi] = &cnt_q[gi];
    end

    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (clear) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else begin
            for (int i = 0; i < N_CNT; i++) begin
                if (inc[i]) begin
                    if (at_max[i]) begin
                        sat_d = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    // in_ready and stat_valid are registered alongside the state, so in_ready
    // never depends combinationally on in_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= COUNT;
            in_ready_q   <= 1'b1;
            stat_valid_q <= 1'b0;
        end else begin
            case (state_q)
                COUNT: begin
                    if (frame_end) begin
                        state_q      <= REPORT;
                        in_ready_q   <= 1'b0;
                        stat_valid_q <= 1'b1;
                    end
                end
                REPORT: begin
                    if (stat_ready) begin
                        state_q      <= COUNT;
                        in_ready_q   <= 1'b1;
                        stat_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= COUNT;
                    in_ready_q   <= 1'b1;
                    stat_valid_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cls_valid_q <= 1'b0;
            cls_q       <= '0;
        end else begin
            cls_valid_q <= accept;
            if (accept) begin
                cls_q <= char_class;
            end
        end
    end

    assign in_ready   = in_ready_q;
    assign stat_valid = stat_valid_q;
    assign cls_valid  = cls_valid_q;
    assign cls        = cls_q;
    assign stat_chars = cnt_q[0];
    assign stat_cap   = cnt_q[1];
    assign stat_lc    = cnt_q[2];
    assign stat_num   = cnt_q[3];
    assign stat_prt   = cnt_q[4];
    assign stat_sat   = sat_q;

endmodule

// File: tb/tb_ascii_frame_stats.sv
// Directed bench: three instances (7-bit/8-bit counters, 7-bit/4-bit counters,
// 8-bit/8-bit counters) driven by one shared character stream.
module tb_ascii_frame_stats;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_last;
    logic       stat_ready;
    logic [7:0] in_char;

    logic       in_ready_a, cls_valid_a, stat_valid_a, stat_sat_a;
    logic [5:0] cls_a;
    logic [7:0] stat_chars_a, stat_cap_a, stat_lc_a, stat_num_a, stat_prt_a;

    logic       in_ready_s, cls_valid_s, stat_valid_s, stat_sat_s;
    logic [5:0] cls_s;
    logic [3:0] stat_chars_s, stat_cap_s, stat_lc_s, stat_num_s, stat_prt_s;

    logic       in_ready_e, cls_valid_e, stat_valid_e, stat_sat_e;
    logic [5:0] cls_e;
    logic [7:0] stat_chars_e, stat_cap_e, stat_lc_e, stat_num_e, stat_prt_e;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    ascii_frame_stats #(.CHAR_W(7), .CNT_W(8), .EOL_CHAR(8'h0A)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_char(in_char[6:0]), .in_last(in_last), .cls_valid(cls_valid_a), .cls(cls_a),
        .stat_valid(stat_valid_a), .stat_ready(stat_ready), .stat_chars(stat_chars_a),
        .stat_cap(stat_cap_a), .stat_lc(stat_lc_a), .stat_num(stat_num_a),
        .stat_prt(stat_prt_a), .stat_sat(stat_sat_a)
    );

    ascii_frame_stats #(.CHAR_W(7), .CNT_W(4), .EOL_CHAR(8'h0A)) u_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_char(in_char[6:0]), .in_last(in_last), .cls_valid(cls_valid_s), .cls(cls_s),
        .stat_valid(stat_valid_s), .stat_ready(stat_ready), .stat_chars(stat_chars_s),
        .stat_cap(stat_cap_s), .stat_lc(stat_lc_s), .stat_num(stat_num_s),
        .stat_prt(stat_prt_s), .stat_sat(stat_sat_s)
    );

    ascii_frame_stats #(.CHAR_W(8), .CNT_W(8), .EOL_CHAR(8'h0A)) u_e (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_e),
        .in_char(in_char), .in_last(in_last), .cls_valid(cls_valid_e), .cls(cls_e),
        .stat_valid(stat_valid_e), .stat_ready(stat_ready), .stat_chars(stat_chars_e),
        .stat_cap(stat_cap_e), .stat_lc(stat_lc_e), .stat_num(stat_num_e),
        .stat_prt(stat_prt_e), .stat_sat(stat_sat_e)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference table: {ext, space, printable, num, lc, cap}.
    function automatic logic [5:0] model_cls(input logic [7:0] c, input bit wide);
        logic [7:0] v;
        logic [5:0] r;
        v    = wide ? c : {1'b0, c[6:0]};
        r[5] = wide && (v >= 8'h80);
        r[4] = (v == 8'h20);
        r[3] = (v >= 8'h21) && (v <= 8'h7E);
        r[2] = (v >= 8'h30) && (v <= 8'h39);
        r[1] = (v >= 8'h61) && (v <= 8'h7A);
        r[0] = (v >= 8'h41) && (v <= 8'h5A);
        return r;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_in_ready",   32'(in_ready_a), 32'd1);
        check("rst_stat_valid", 32'(stat_valid_a), 32'd0);
        check("rst_cls_valid",  32'(cls_valid_a), 32'd0);
        check("rst_cls",        32'(cls_a), 32'd0);
        check("rst_chars",      32'(stat_chars_a), 32'd0);
        check("rst_sat",        32'(stat_sat_a), 32'd0);
    endtask

    task automatic send(input logic [7:0] c, input logic last);
        int w = 0;
        while (!in_ready_a && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        check("in_ready_before_send", 32'(in_ready_a), 32'd1);
        in_char  = c;
        in_last  = last;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("cls_valid_a", 32'(cls_valid_a), 32'd1);
        check($sformatf("cls_a[%02h]", c), 32'(cls_a), 32'(model_cls(c, 1'b0)));
        check($sformatf("cls_s[%02h]", c), 32'(cls_s), 32'(model_cls(c, 1'b0)));
        check($sformatf("cls_e[%02h]", c), 32'(cls_e), 32'(model_cls(c, 1'b1)));
        check("lockstep_ready", 32'({in_ready_s, in_ready_e, cls_valid_e}), 32'({in_ready_a, in_ready_a, 1'b1}));
    endtask

    task automatic report(input int chars, input int cap, input int lc, input int num,
                          input int prt, input int sat);
        check("stat_valid", 32'(stat_valid_a), 32'd1);
        check("stat_chars", 32'(stat_chars_a), 32'(chars));
        check("stat_cap",   32'(stat_cap_a), 32'(cap));
        check("stat_lc",    32'(stat_lc_a), 32'(lc));
        check("stat_num",   32'(stat_num_a), 32'(num));
        check("stat_prt",   32'(stat_prt_a), 32'(prt));
        check("stat_sat",   32'(stat_sat_a), 32'(sat));
        $display("frame: chars=%0d cap=%0d lc=%0d num=%0d prt=%0d sat=%0d",
                 stat_chars_a, stat_cap_a, stat_lc_a, stat_num_a, stat_prt_a, stat_sat_a);
        stat_ready = 1'b1;
        @(posedge clk); #1;
        stat_ready = 1'b0;
        check("released_valid", 32'(stat_valid_a), 32'd0);
        check("released_ready", 32'(in_ready_a), 32'd1);
        check("cleared_chars",  32'(stat_chars_a), 32'd0);
    endtask

    initial begin
        string s;
        rst_n      = 1'b1;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        in_char    = 8'h00;
        stat_ready = 1'b0;
        @(posedge clk); #1;
        do_reset();

        // "Ab3 x!" + LF
        s = "Ab3 x!";
        for (int i = 0; i < s.len(); i++) send(s[i], 1'b0);
        send(8'h0A, 1'b0);
        check("e_chars7", 32'(stat_chars_e), 32'd7);
        report(7, 1, 2, 1, 5, 0);

        // Full 7-bit sweep; LF closes the first frame, in_last on 0x7F the second.
        for (int c = 0; c <= 8'h0A; c++) send(8'(c), 1'b0);
        check("s_sweep1_chars", 32'(stat_chars_s), 32'd11);
        report(11, 0, 0, 0, 0, 0);
        for (int c = 8'h0B; c <= 8'h7F; c++) send(8'(c), (c == 8'h7F));
        check("s_sweep2_chars", 32'(stat_chars_s), 32'd15);
        check("s_sweep2_sat",   32'(stat_sat_s), 32'd1);
        report(117, 26, 26, 10, 94, 0);

        // Backpressure: stats held, offered characters refused.
        send("h", 1'b0);
        send("i", 1'b0);
        send(8'h0A, 1'b0);
        in_char  = "Z";
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("bp_in_ready",  32'(in_ready_a), 32'd0);
            check("bp_valid",     32'(stat_valid_a), 32'd1);
            check("bp_chars",     32'(stat_chars_a), 32'd3);
            check("bp_lc",        32'(stat_lc_a), 32'd2);
            check("bp_cls_valid", 32'(cls_valid_a), 32'd0);
        end
        in_valid = 1'b0;
        report(3, 0, 2, 0, 2, 0);
        send("Q", 1'b1);
        report(1, 1, 0, 0, 1, 0);
        send(8'h0A, 1'b0);
        report(1, 0, 0, 0, 0, 0);

        // LF together with in_last: exactly one frame end.
        send(8'h0A, 1'b1);
        report(1, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        check("single_end_valid", 32'(stat_valid_a), 32'd0);

        // Saturation on the 4-bit-counter instance.
        for (int k = 0; k < 20; k++) send("a", 1'b0);
        send(8'h0A, 1'b0);
        check("s_valid", 32'(stat_valid_s), 32'd1);
        check("s_chars", 32'(stat_chars_s), 32'd15);
        check("s_lc",    32'(stat_lc_s), 32'd15);
        check("s_prt",   32'(stat_prt_s), 32'd15);
        check("s_capnum", 32'({stat_cap_s, stat_num_s}), 32'd0);
        check("s_sat",   32'(stat_sat_s), 32'd1);
        report(21, 0, 20, 0, 20, 0);
        send("b", 1'b0);
        send(8'h0A, 1'b0);
        check("s_next_chars", 32'(stat_chars_s), 32'd2);
        check("s_next_sat",   32'(stat_sat_s), 32'd0);
        report(2, 0, 1, 0, 1, 0);

        // Extended code on the 8-bit instance.
        send(8'hC1, 1'b0);
        send(8'h41, 1'b0);
        send(8'h00, 1'b1);
        check("e_valid", 32'(stat_valid_e), 32'd1);
        check("e_chars", 32'(stat_chars_e), 32'd3);
        check("e_cap",   32'(stat_cap_e), 32'd1);
        check("e_prt",   32'(stat_prt_e), 32'd1);
        check("e_lcnum", 32'({stat_lc_e, stat_num_e}), 32'd0);
        check("e_sat",   32'(stat_sat_e), 32'd0);
        report(3, 2, 0, 0, 2, 0);

        // Reset mid-frame, then during REPORT.
        send("a", 1'b0);
        send("b", 1'b0);
        send("c", 1'b0);
        do_reset();
        send("x", 1'b0);
        send(8'h0A, 1'b0);
        report(2, 0, 1, 0, 1, 0);
        send("k", 1'b0);
        send(8'h0A, 1'b0);
        check("pre_rst_report", 32'(stat_valid_a), 32'd1);
        do_reset();
        send("M", 1'b1);
        report(1, 1, 0, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

endmodule
